// File: rtl/adc_seq_pkg.sv
// Shared types and LTC2308 framing constants for the ADC scan controller.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    XFER = 2'd2
  } seq_state_t;

  localparam int LTC_FRAME_BITS = 12;
  localparam int MAX_CH         = 8;

  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  // Single-ended, unipolar; the odd/sign bit carries ch[0], S1:S0 carry ch[2:1].
  function automatic logic [LTC_FRAME_BITS-1:0] cfg_word(input logic [2:0] ch);
    return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP, 6'b0};
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// Twelve-bit full-duplex shifter for the LTC2308 frame: generates sclk,
// drives din MSB first and captures dout on the last low cycle of each bit.
module adc_spi_shifter
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LTC_FRAME_BITS-1:0] tx_word,
  input  logic                      dout,
  output logic                      done,
  output logic [LTC_FRAME_BITS-1:0] rx_word,
  output logic                      sclk,
  output logic                      din
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic                      active;
  logic                      high;
  logic [DIV_W-1:0]          div_cnt;
  logic [3:0]                bit_cnt;
  logic [LTC_FRAME_BITS-1:0] tx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      high    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_word <= '0;
    end else if (start) begin
      active  <= 1'b1;
      high    <= 1'b0;
      div_cnt <= DIV_W'(CLK_DIV - 1);
      bit_cnt <= 4'(LTC_FRAME_BITS - 1);
      tx_sr   <= tx_word;
    end else if (active) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_W'(CLK_DIV - 1);
        if (!high) begin
          // last low cycle: sample just before sclk rises
          high    <= 1'b1;
          rx_word <= {rx_word[LTC_FRAME_BITS-2:0], dout};
        end else if (bit_cnt == '0) begin
          active <= 1'b0;
          high   <= 1'b0;
        end else begin
          high    <= 1'b0;
          bit_cnt <= bit_cnt - 1'b1;
          tx_sr   <= {tx_sr[LTC_FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign done = active & high & (div_cnt == '0) & (bit_cnt == '0);
  assign sclk = active & high;
  assign din  = active & tx_sr[LTC_FRAME_BITS-1];

endmodule

// File: rtl/adc_seq_ctrl.sv
// LTC2308 round-robin scan controller with per-channel averaging and a
// latest-value register bank.
//   state | meaning
//   IDLE  | not scanning, cs_n high, next frame unprimed
//   CONV  | cs_n high for CONV_CYCLES while the ADC converts
//   XFER  | cs_n low, shift out next config / shift in previous result
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              result_valid,
  output logic [2:0]        result_ch,
  output logic [DATA_W-1:0] result_data,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              adc_external_interface_sclk,
  output logic              adc_external_interface_cs_n,
  input  logic              adc_external_interface_dout,
  output logic              adc_external_interface_din
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int CNV_W = $clog2(CONV_CYCLES + 1);

  seq_state_t                state, state_nxt;
  logic [CNV_W-1:0]          conv_cnt;
  logic [2:0]                cfg_ch;
  logic [2:0]                ch_sent;
  logic                      primed;
  logic                      run;
  logic                      frame_start;
  logic                      shift_start;
  logic                      shift_done;
  logic [LTC_FRAME_BITS-1:0] rx_word;
  logic [ACC_W-1:0]          acc_sum;
  logic                      cnt_hit;
  logic [ACC_W-1:0]          acc  [MAX_CH];
  logic [CNT_W-1:0]          cnt  [MAX_CH];
  logic [DATA_W-1:0]         bank [MAX_CH];

  function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // lowest enabled channel above cur, else wrap to the lowest enabled
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = first_ch(m);
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i] && (3'(i) > cur)) r = 3'(i);
    return r;
  endfunction

  assign run = enable & (|ch_mask);

  always_comb begin
    state_nxt   = state;
    shift_start = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = CONV;
      CONV: begin
        if (conv_cnt == '0) begin
          state_nxt   = XFER;
          shift_start = 1'b1;
        end
      end
      XFER: if (shift_done) state_nxt = run ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_start = (state_nxt == CONV) && (state != CONV);
  assign acc_sum     = acc[ch_sent] + ACC_W'(DATA_W'(rx_word));
  assign cnt_hit     = (cnt[ch_sent] == CNT_W'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      conv_cnt     <= '0;
      cfg_ch       <= '0;
      ch_sent      <= '0;
      primed       <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      for (int i = 0; i < MAX_CH; i++) begin
        acc[i]  <= '0;
        cnt[i]  <= '0;
        bank[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      if (frame_start) begin
        conv_cnt <= CNV_W'(CONV_CYCLES - 1);
        cfg_ch   <= (state == IDLE) ? first_ch(ch_mask) : next_ch(cfg_ch, ch_mask);
      end else if (conv_cnt != '0) begin
        conv_cnt <= conv_cnt - 1'b1;
      end
      if (shift_done) begin
        ch_sent <= cfg_ch;
        primed  <= run;
        if (primed) begin
          if (cnt_hit) begin
            result_valid <= 1'b1;
            result_ch    <= ch_sent;
            result_data  <= DATA_W'(acc_sum >> AVG_LOG2);
            acc[ch_sent] <= '0;
            cnt[ch_sent] <= '0;
          end else begin
            acc[ch_sent] <= acc_sum;
            cnt[ch_sent] <= cnt[ch_sent] + 1'b1;
          end
        end
      end
      if (result_valid) bank[result_ch] <= result_data;
    end
  end

  assign rd_data = (int'(rd_ch) < NUM_CH) ? bank[rd_ch] : '0;
  assign adc_external_interface_cs_n = (state != XFER);

  adc_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .start   (shift_start),
    .tx_word (cfg_word(cfg_ch)),
    .dout    (adc_external_interface_dout),
    .done    (shift_done),
    .rx_word (rx_word),
    .sclk    (adc_external_interface_sclk),
    .din     (adc_external_interface_din)
  );

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: two instances (defaults, and CLK_DIV=3/AVG_LOG2=2)
// driven by a behavioural LTC2308 model, results checked against a queue.
module tb_adc_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  enable = 2'b00;
  logic [7:0]  mask_a = 8'h00;
  logic [5:0]  mask_b = 6'h00;
  logic [1:0]  rv;
  logic [2:0]  rch [2];
  logic [11:0] rdat [2];
  logic [2:0]  rd_sel [2] = '{3'd0, 3'd0};
  logic [11:0] rd_data [2];
  logic [1:0]  sclk, cs_n, din;
  logic [1:0]  dout = 2'b00;

  adc_seq_ctrl u_a (
    .clk_clk(clk), .reset_reset(rst), .enable(enable[0]), .ch_mask(mask_a),
    .result_valid(rv[0]), .result_ch(rch[0]), .result_data(rdat[0]),
    .rd_ch(rd_sel[0]), .rd_data(rd_data[0]),
    .adc_external_interface_sclk(sclk[0]), .adc_external_interface_cs_n(cs_n[0]),
    .adc_external_interface_dout(dout[0]), .adc_external_interface_din(din[0])
  );

  adc_seq_ctrl #(.NUM_CH(6), .CLK_DIV(3), .CONV_CYCLES(20), .AVG_LOG2(2)) u_b (
    .clk_clk(clk), .reset_reset(rst), .enable(enable[1]), .ch_mask(mask_b),
    .result_valid(rv[1]), .result_ch(rch[1]), .result_data(rdat[1]),
    .rd_ch(rd_sel[1]), .rd_data(rd_data[1]),
    .adc_external_interface_sclk(sclk[1]), .adc_external_interface_cs_n(cs_n[1]),
    .adc_external_interface_dout(dout[1]), .adc_external_interface_din(din[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: each frame returns the word produced by the previous frame's config.
  int          div_of [2] = '{2, 3};
  logic [11:0] word [2] = '{12'h0AA, 12'h0AA};
  logic [11:0] cfg_sr [2] = '{12'h000, 12'h000};
  logic [11:0] cfg_hist [2][64];
  int          cfg_n [2] = '{0, 0};
  int          bit_idx [2] = '{0, 0};
  int          low_run [2] = '{0, 0};
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_cs = 2'b11;
  logic        avg_on = 1'b0;
  logic [11:0] samp_arr [4] = '{12'd0, 12'd0, 12'd0, 12'd0};
  int          samp_idx = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_n[k] === 1'b1) begin
        if (prev_cs[k] === 1'b0) begin
          cfg_hist[k][cfg_n[k] % 64] = cfg_sr[k];
          cfg_n[k] = cfg_n[k] + 1;
          if (k == 0) word[k] = 12'h100 + {9'd0, cfg_sr[k][9], cfg_sr[k][8], cfg_sr[k][10]};
          else if (avg_on && samp_idx < 4) begin
            word[k] = samp_arr[samp_idx];
            samp_idx = samp_idx + 1;
          end else word[k] = 12'h0AA;
        end
        bit_idx[k] = 0;
        low_run[k] = 0;
      end else if (sclk[k] === 1'b1) begin
        if (prev_sclk[k] === 1'b0) begin
          bit_idx[k] = bit_idx[k] + 1;
          cfg_sr[k]  = {cfg_sr[k][10:0], din[k]};
        end
        low_run[k] = 0;
      end else begin
        low_run[k] = low_run[k] + 1;
      end
      // the true bit is only presented on the last low cycle before sclk rises
      if (cs_n[k] === 1'b0 && sclk[k] === 1'b0 && bit_idx[k] < 12)
        dout[k] = word[k][11 - bit_idx[k]] ^ (low_run[k] != div_of[k]);
      else
        dout[k] = 1'b0;
      prev_sclk[k] = sclk[k];
      prev_cs[k]   = cs_n[k];
    end
  end

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic wait_result(input int k, input int budget, output logic [2:0] ch,
                             output logic [11:0] d, output logic ok);
    ok = 1'b0; ch = '0; d = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rv[k] === 1'b1) begin
        ch = rch[k]; d = rdat[k]; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs_low(input int k, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs_n[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cs_n !== 2'b11) begin n_bad++; $display("FAIL reset_cs_n: got %b want 11", cs_n); end
    n_cmp++; if (sclk !== 2'b00) begin n_bad++; $display("FAIL reset_sclk: got %b want 00", sclk); end
    n_cmp++; if (din !== 2'b00) begin n_bad++; $display("FAIL reset_din: got %b want 00", din); end
    n_cmp++; if (rv !== 2'b00) begin n_bad++; $display("FAIL reset_valid: got %b want 00", rv); end
    n_cmp++; if (rch[0] !== 3'd0 || rdat[0] !== 12'd0) begin
      n_bad++; $display("FAIL reset_result: got ch %0d data %0h want 0/0", rch[0], rdat[0]);
    end
    n_cmp++; if (rd_data[0] !== 12'd0) begin n_bad++; $display("FAIL reset_bank: got %0h want 0", rd_data[0]); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_scan();
    int base, tprev;
    logic [2:0] ch; logic [11:0] d; logic ok; res_t e;
    base = cfg_n[0];
    exp_q.push_back('{3'd0, 12'h100});
    exp_q.push_back('{3'd1, 12'h101});
    exp_q.push_back('{3'd2, 12'h102});
    exp_q.push_back('{3'd0, 12'h100});
    mask_a = 8'h07; enable[0] = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_result(0, 400, ch, d, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || ch !== e.ch || d !== e.data) begin
        n_bad++; $display("FAIL basic_result[%0d]: got ok=%0b ch %0d data %0h want ch %0d data %0h", i, ok, ch, d, e.ch, e.data);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - tprev != 128) begin n_bad++; $display("FAIL basic_period: got %0d want 128", cyc - tprev); end
      end
      tprev = cyc;
    end
    @(negedge clk);
    n_cmp++; if (cfg_hist[0][base % 64] !== 12'h880) begin
      n_bad++; $display("FAIL basic_cfg_first: got %0h want 880", cfg_hist[0][base % 64]);
    end
    n_cmp++; if (cfg_hist[0][(base + 1) % 64] !== 12'hC80) begin
      n_bad++; $display("FAIL basic_cfg_second: got %0h want c80", cfg_hist[0][(base + 1) % 64]);
    end
  endtask

  task automatic test_disable_mid_xfer();
    logic [2:0] ch; logic [11:0] d; logic ok; res_t e;
    int lows, vals, t0;
    wait_cs_low(0, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL disable_wait_xfer: got timeout want cs_n low"); end
    repeat (10) @(negedge clk);
    enable[0] = 1'b0;
    exp_q.push_back('{3'd1, 12'h101});
    wait_result(0, 200, ch, d, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || ch !== e.ch || d !== e.data) begin
      n_bad++; $display("FAIL disable_last_result: got ok=%0b ch %0d data %0h want ch %0d data %0h", ok, ch, d, e.ch, e.data);
    end
    lows = 0; vals = 0;
    repeat (300) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1) lows++;
      if (rv[0] !== 1'b0) vals++;
    end
    n_cmp++; if (lows != 0 || vals != 0) begin
      n_bad++; $display("FAIL disable_idle: got %0d xfer cycles %0d results want 0/0", lows, vals);
    end
    t0 = cyc;
    enable[0] = 1'b1;
    exp_q.push_back('{3'd0, 12'h100});
    wait_result(0, 400, ch, d, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || ch !== e.ch || d !== e.data) begin
      n_bad++; $display("FAIL restart_result: got ok=%0b ch %0d data %0h want ch %0d data %0h", ok, ch, d, e.ch, e.data);
    end
    n_cmp++; if (cyc - t0 < 256) begin n_bad++; $display("FAIL restart_unprimed: got %0d cycles want >=256", cyc - t0); end
    enable[0] = 1'b0;
    repeat (400) @(negedge clk);
  endtask

  task automatic test_empty_mask();
    int lows, vals;
    mask_a = 8'h00; enable[0] = 1'b1;
    lows = 0; vals = 0;
    repeat (300) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1) lows++;
      if (rv[0] !== 1'b0) vals++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL empty_cs_n: got %0d low cycles want 0", lows); end
    n_cmp++; if (vals != 0) begin n_bad++; $display("FAIL empty_valid: got %0d results want 0", vals); end
    enable[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sparse_wrap();
    logic [2:0] ch; logic [11:0] d; logic ok; res_t e;
    exp_q.push_back('{3'd0, 12'h100});
    exp_q.push_back('{3'd7, 12'h107});
    exp_q.push_back('{3'd0, 12'h100});
    exp_q.push_back('{3'd7, 12'h107});
    exp_q.push_back('{3'd0, 12'h100});
    exp_q.push_back('{3'd7, 12'h107});
    exp_q.push_back('{3'd2, 12'h102});
    exp_q.push_back('{3'd2, 12'h102});
    mask_a = 8'h81; enable[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_result(0, 400, ch, d, ok);
      if (i == 3) mask_a = 8'h04;
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || ch !== e.ch || d !== e.data) begin
        n_bad++; $display("FAIL sparse_result[%0d]: got ok=%0b ch %0d data %0h want ch %0d data %0h", i, ok, ch, d, e.ch, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic ok; logic p; int rises, guard;
    rd_sel[0] = 3'd2;
    @(negedge clk);
    n_cmp++; if (rd_data[0] !== 12'h102) begin n_bad++; $display("FAIL bank_before_reset: got %0h want 102", rd_data[0]); end
    wait_cs_low(0, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_wait_xfer: got timeout want cs_n low"); end
    rises = 0; guard = 0; p = 1'b0;
    while (rises < 5 && guard < 200) begin
      @(negedge clk);
      if (sclk[0] === 1'b1 && !p) rises++;
      p = sclk[0];
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || din[0] !== 1'b0 || rv[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_pins: got cs_n %b sclk %b din %b valid %b want 1/0/0/0", cs_n[0], sclk[0], din[0], rv[0]);
    end
    n_cmp++; if (rd_data[0] !== 12'h000) begin n_bad++; $display("FAIL reset_mid_bank: got %0h want 0", rd_data[0]); end
    rst = 1'b0; enable[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_bit_timing();
    logic ok, level; int len, run, bad, rises;
    mask_b = 6'h01; enable[1] = 1'b1;
    wait_cs_low(1, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL timing_wait_xfer: got timeout want cs_n low"); end
    level = 1'b0; run = 0; len = 0; bad = 0; rises = 0;
    while (cs_n[1] === 1'b0 && len < 200) begin
      len++;
      if (sclk[1] === level) run++;
      else begin
        if (run != 3) bad++;
        if (sclk[1] === 1'b1) rises++;
        level = sclk[1]; run = 1;
      end
      @(negedge clk);
    end
    if (run != 3) bad++;
    n_cmp++; if (len != 72) begin n_bad++; $display("FAIL timing_xfer_len: got %0d want 72", len); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL timing_phases: got %0d bad runs want 0", bad); end
    n_cmp++; if (rises != 12) begin n_bad++; $display("FAIL timing_edges: got %0d want 12", rises); end
    enable[1] = 1'b0;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_averaging();
    logic [2:0] ch; logic [11:0] d; logic ok; res_t e; int base;
    samp_arr = '{12'd10, 12'd11, 12'd12, 12'd14};
    avg_on = 1'b1;
    base = cfg_n[1];
    rd_sel[1] = 3'd5;
    exp_q.push_back('{3'd5, 12'd11});
    mask_b = 6'h20; enable[1] = 1'b1;
    wait_result(1, 700, ch, d, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || ch !== e.ch || d !== e.data) begin
      n_bad++; $display("FAIL avg_result: got ok=%0b ch %0d data %0d want ch %0d data %0d", ok, ch, d, e.ch, e.data);
    end
    @(negedge clk);
    n_cmp++; if (rd_data[1] !== 12'd11) begin n_bad++; $display("FAIL avg_bank: got %0d want 11", rd_data[1]); end
    rd_sel[1] = 3'd6;
    @(negedge clk);
    n_cmp++; if (rd_data[1] !== 12'd0) begin n_bad++; $display("FAIL bank_out_of_range: got %0h want 0", rd_data[1]); end
    n_cmp++; if (cfg_hist[1][base % 64] !== 12'hE80) begin
      n_bad++; $display("FAIL avg_cfg: got %0h want e80", cfg_hist[1][base % 64]);
    end
    enable[1] = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_disable_mid_xfer();
    test_empty_mask();
    test_sparse_wrap();
    test_reset_mid_xfer();
    test_bit_timing();
    test_averaging();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
